// File: rtl/nonce_gen_mc.sv
`default_nettype none
// ============================================================================
// Module   : nonce_gen_mc
// Purpose  : Loads an 80-byte header and hands one 11-beat hash-input frame
//            per nonce of this instance's slice to NUM_LANES hash cores.
// Revision : 1.0 - initial multi-lane release
// ============================================================================
module nonce_gen_mc #(
    parameter int          NUM_LANES  = 4,
    parameter int          NONCE_COEF = 1,
    parameter logic [63:0] PAD_WORD   = 64'h8000000000000280
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic                 i_hdr_valid,
    input  logic [31:0]          i_hdr_data,
    output logic                 o_hdr_ready,
    input  logic [31:0]          i_nonce_size,
    output logic [NUM_LANES-1:0] o_hashin_we,
    output logic [63:0]          o_hashin_din,
    input  logic [NUM_LANES-1:0] i_hashin_full,
    output logic [NUM_LANES-1:0] o_nonce_we,
    output logic [31:0]          o_nonce_din,
    input  logic [NUM_LANES-1:0] i_nonce_full,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [31:0]          o_nonce_last,
    output logic [31:0]          o_issued_cnt
);

    localparam int          c_LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [63:0] c_COEF_M1 = 64'(NONCE_COEF - 1);
    localparam logic [32:0] c_TOP     = 33'h1_0000_0000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ARM   = 3'd2,
        S_SEL   = 3'd3,
        S_FRAME = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [19:0][31:0]    r_hdr;
    logic [4:0]           r_wcnt;
    logic [32:0]          r_n;
    logic [32:0]          r_end;
    logic [c_LANE_W-1:0]  r_ptr;
    logic [c_LANE_W-1:0]  r_lane;
    logic [3:0]           r_beat;
    logic [31:0]          r_nonce_last;
    logic [31:0]          r_issued;
    logic                 r_done_end;

    logic [63:0]          w_s;
    logic [63:0]          w_e;
    logic [32:0]          w_E;
    logic                 w_empty;
    logic [NUM_LANES-1:0] w_free;
    logic [NUM_LANES-1:0] w_rot;
    logic                 w_found;
    logic [c_LANE_W:0]    w_sum;
    logic [c_LANE_W-1:0]  w_sel;
    logic [c_LANE_W-1:0]  w_ptr_nxt;
    logic [NUM_LANES-1:0] w_sel_mask;
    logic [NUM_LANES-1:0] w_lane_mask;
    logic                 w_lane_full;
    logic [31:0]          w_bswap;
    logic [9:0][63:0]     w_frame;
    logic [3:0]           w_slot;
    logic [32:0]          w_n_inc;
    logic                 w_done_now;
    logic                 w_beat_go;

    // Slice bounds; the exclusive end saturates at 2^32 so the last nonce never wraps.
    assign w_s     = {32'd0, r_hdr[0]} + 64'(i_nonce_size) * c_COEF_M1;
    assign w_e     = w_s + 64'(i_nonce_size);
    assign w_E     = (w_e > 64'(c_TOP)) ? c_TOP : w_e[32:0];
    assign w_empty = (w_s >= 64'(w_E));

    // Rotate the eligibility vector so bit 0 is the pointer lane; lowest set bit wins.
    assign w_free = ~i_hashin_full & ~i_nonce_full;
    assign w_rot  = NUM_LANES'({w_free, w_free} >> r_ptr);

    always_comb begin
        w_found = 1'b0;
        w_sum   = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_ptr} + (c_LANE_W + 1)'(i);
            end
        end
        if (w_sum >= (c_LANE_W + 1)'(NUM_LANES)) begin
            w_sum = w_sum - (c_LANE_W + 1)'(NUM_LANES);
        end
    end

    assign w_sel       = w_sum[c_LANE_W-1:0];
    assign w_ptr_nxt   = (w_sel == c_LANE_W'(NUM_LANES - 1)) ? '0 : w_sel + c_LANE_W'(1);
    assign w_sel_mask  = NUM_LANES'(1) << w_sel;
    assign w_lane_mask = NUM_LANES'(1) << r_lane;
    assign w_lane_full = |(i_hashin_full & w_lane_mask);

    assign w_bswap = {r_n[7:0], r_n[15:8], r_n[23:16], r_n[31:24]};
    assign w_frame = {r_hdr[19:1], w_bswap};
    assign w_slot  = 4'd10 - r_beat;
    assign w_n_inc = r_n + 33'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        o_hdr_ready  = 1'b0;
        o_hashin_we  = '0;
        o_hashin_din = '0;
        o_nonce_we   = '0;
        o_nonce_din  = '0;
        w_done_now   = 1'b0;
        w_beat_go    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_LOAD;
            end
            S_LOAD: begin
                o_hdr_ready = 1'b1;
                if (i_hdr_valid && (r_wcnt == 5'd19)) w_next = S_ARM;
            end
            S_ARM: begin
                if (w_empty) begin
                    w_done_now = 1'b1;
                    w_next     = S_IDLE;
                end else begin
                    w_next = S_SEL;
                end
            end
            S_SEL: begin
                if (i_stop) begin
                    w_done_now = 1'b1;
                    w_next     = S_IDLE;
                end else if (w_found) begin
                    o_hashin_we  = w_sel_mask;
                    o_hashin_din = PAD_WORD;
                    o_nonce_we   = w_sel_mask;
                    o_nonce_din  = r_n[31:0];
                    w_next       = S_FRAME;
                end
            end
            S_FRAME: begin
                if (!w_lane_full) begin
                    o_hashin_we  = w_lane_mask;
                    o_hashin_din = w_frame[w_slot];
                    w_beat_go    = 1'b1;
                    if (r_beat == 4'd10) begin
                        w_next = (w_n_inc == r_end) ? S_IDLE : S_SEL;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hdr        <= '0;
            r_wcnt       <= '0;
            r_n          <= '0;
            r_end        <= '0;
            r_ptr        <= '0;
            r_lane       <= '0;
            r_beat       <= '0;
            r_nonce_last <= '0;
            r_issued     <= '0;
            r_done_end   <= 1'b0;
        end else begin
            r_done_end <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_wcnt   <= '0;
                        r_issued <= '0;
                    end
                end
                S_LOAD: begin
                    if (i_hdr_valid) begin
                        r_hdr[r_wcnt] <= i_hdr_data;
                        r_wcnt        <= r_wcnt + 5'd1;
                    end
                end
                S_ARM: begin
                    if (!w_empty) begin
                        r_n          <= w_s[32:0];
                        r_end        <= w_E;
                        r_nonce_last <= w_E[31:0] - 32'd1;
                    end
                end
                S_SEL: begin
                    if (!i_stop && w_found) begin
                        r_lane <= w_sel;
                        r_ptr  <= w_ptr_nxt;
                        r_beat <= 4'd1;
                    end
                end
                S_FRAME: begin
                    if (w_beat_go) begin
                        r_beat <= r_beat + 4'd1;
                        if (r_beat == 4'd10) begin
                            r_n        <= w_n_inc;
                            r_issued   <= r_issued + 32'd1;
                            r_done_end <= (w_n_inc == r_end);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = w_done_now | r_done_end;
    assign o_nonce_last = r_nonce_last;
    assign o_issued_cnt = r_issued;

endmodule
`default_nettype wire

// File: tb/tb_nonce_gen_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_nonce_gen_mc
// Purpose  : Scoreboard bench: one single-lane and one four-lane instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nonce_gen_mc;

    localparam logic [63:0] c_PAD = 64'h8000000000000280;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stop, hdr_valid;
    logic [31:0] hdr_data, nonce_size;
    logic        start_a, start_b;

    logic [0:0]  a_hwe, a_hfull, a_nwe, a_nfull;
    logic [63:0] a_hdin;
    logic [31:0] a_ndin, a_last, a_iss;
    logic        a_rdy, a_busy, a_done;

    logic [3:0]  b_hwe, b_hfull, b_nwe, b_nfull;
    logic [63:0] b_hdin;
    logic [31:0] b_ndin, b_last, b_iss;
    logic        b_rdy, b_busy, b_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int xfer_cyc = 0;

    int a_hw_n = 0, a_last_hw = 0, a_done_n = 0, a_done_cyc = 0;
    int b_hw_n = 0, b_last_hw = 0, b_nw_n = 0, b_last_nw = 0, b_done_n = 0, b_done_cyc = 0;

    logic [67:0] qha[$], qhb[$];
    logic [35:0] qna[$], qnb[$];
    logic [31:0] hdr[20];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nonce_gen_mc #(.NUM_LANES(1), .NONCE_COEF(1), .PAD_WORD(c_PAD)) u_a (
        .clk(clk), .rst(rst), .i_start(start_a), .i_stop(stop),
        .i_hdr_valid(hdr_valid), .i_hdr_data(hdr_data), .o_hdr_ready(a_rdy),
        .i_nonce_size(nonce_size),
        .o_hashin_we(a_hwe), .o_hashin_din(a_hdin), .i_hashin_full(a_hfull),
        .o_nonce_we(a_nwe), .o_nonce_din(a_ndin), .i_nonce_full(a_nfull),
        .o_busy(a_busy), .o_done(a_done), .o_nonce_last(a_last), .o_issued_cnt(a_iss)
    );

    nonce_gen_mc #(.NUM_LANES(4), .NONCE_COEF(2), .PAD_WORD(c_PAD)) u_b (
        .clk(clk), .rst(rst), .i_start(start_b), .i_stop(stop),
        .i_hdr_valid(hdr_valid), .i_hdr_data(hdr_data), .o_hdr_ready(b_rdy),
        .i_nonce_size(nonce_size),
        .o_hashin_we(b_hwe), .o_hashin_din(b_hdin), .i_hashin_full(b_hfull),
        .o_nonce_we(b_nwe), .o_nonce_din(b_ndin), .i_nonce_full(b_nfull),
        .o_busy(b_busy), .o_done(b_done), .o_nonce_last(b_last), .o_issued_cnt(b_iss)
    );

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected frame: PAD, then {w19,w18} .. {w1, byte-swapped nonce}.
    task automatic push_frame(input bit sel, input logic [3:0] lane, input logic [31:0] n);
        logic [63:0] beat;
        for (int b = 0; b <= 10; b++) begin
            if (b == 0)       beat = c_PAD;
            else if (b == 10) beat = {hdr[1], n[7:0], n[15:8], n[23:16], n[31:24]};
            else              beat = {hdr[21-2*b], hdr[20-2*b]};
            if (sel) qhb.push_back({lane, beat});
            else     qha.push_back({lane, beat});
        end
        if (sel) qnb.push_back({lane, n});
        else     qna.push_back({lane, n});
    endtask

    task automatic mon_one(input bit sel, input logic [3:0] hwe, input logic [63:0] hd,
                           input logic [3:0] nwe, input logic [31:0] nd);
        logic [3:0]  lane;
        logic [67:0] eh;
        logic [35:0] en;
        lane = 4'd0;
        for (int i = 0; i < 4; i++) if (hwe[i]) lane = 4'(i);
        if (hwe != 4'd0) begin
            chk(sel ? "b_hwe_onehot" : "a_hwe_onehot", 72'($countones(hwe)), 72'd1);
            if ((sel && qhb.size() == 0) || (!sel && qha.size() == 0)) begin
                chk(sel ? "b_unexpected_hashin" : "a_unexpected_hashin", {lane, hd}, 72'd0);
            end else begin
                eh = sel ? qhb.pop_front() : qha.pop_front();
                chk(sel ? "b_hashin_beat" : "a_hashin_beat", {lane, hd}, eh);
            end
        end else begin
            chk(sel ? "b_hdin_idle" : "a_hdin_idle", hd, 72'd0);
        end
        lane = 4'd0;
        for (int i = 0; i < 4; i++) if (nwe[i]) lane = 4'(i);
        if (nwe != 4'd0) begin
            if ((sel && qnb.size() == 0) || (!sel && qna.size() == 0)) begin
                chk(sel ? "b_unexpected_nonce" : "a_unexpected_nonce", {lane, nd}, 72'd0);
            end else begin
                en = sel ? qnb.pop_front() : qna.pop_front();
                chk(sel ? "b_nonce_write" : "a_nonce_write", {lane, nd}, en);
            end
        end else begin
            chk(sel ? "b_ndin_idle" : "a_ndin_idle", nd, 72'd0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon_one(1'b0, {3'b0, a_hwe}, a_hdin, {3'b0, a_nwe}, a_ndin);
            mon_one(1'b1, b_hwe, b_hdin, b_nwe, b_ndin);
            if (|a_hwe) begin a_hw_n++; a_last_hw = cyc; end
            if (a_done) begin a_done_n++; a_done_cyc = cyc; end
            if (|b_hwe) begin b_hw_n++; b_last_hw = cyc; end
            if (|b_nwe) begin b_nw_n++; b_last_nw = cyc; end
            if (b_done) begin b_done_n++; b_done_cyc = cyc; end
        end
    end

    task automatic start_job(input bit sel);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        chk("ready_before_start", sel ? b_rdy : a_rdy, 72'd0);
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        chk("start_to_ready", sel ? b_rdy : a_rdy, 72'd1);
    endtask

    task automatic send_hdr(input bit sel, input int nwords, input bit gap);
        int g;
        for (int k = 0; k < nwords; k++) begin
            if (gap && k == 5) begin hdr_valid = 1'b0; tick(); end
            hdr_valid = 1'b1;
            hdr_data  = hdr[k];
            g = 0;
            while (!(sel ? b_rdy : a_rdy) && g < 50) begin tick(); g++; end
            if (g >= 50) chk("hdr_ready_timeout", 72'd0, 72'd1);
            xfer_cyc = cyc;
            tick();
        end
        hdr_valid = 1'b0;
        hdr_data  = '0;
    endtask

    task automatic wait_idle(input bit sel, input int budget);
        int k;
        k = 0;
        while ((sel ? b_busy : a_busy) && k < budget) begin tick(); k++; end
        chk("job_finish_timeout", sel ? b_busy : a_busy, 72'd0);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, n0, d0, k, g;
        stop = 0; hdr_valid = 0; hdr_data = 0; nonce_size = 0;
        start_a = 0; start_b = 0;
        a_hfull = 0; a_nfull = 0; b_hfull = 0; b_nfull = 0;
        for (int i = 0; i < 20; i++) hdr[i] = 32'hC0DE_0000 | 32'(i);
        repeat (3) tick();

        chk("rst_a_ctrl", {a_rdy, a_busy, a_done, a_hwe, a_nwe}, 72'd0);
        chk("rst_a_cnt", {a_last, a_iss}, 72'd0);
        chk("rst_b_ctrl", {b_rdy, b_busy, b_done, b_hwe, b_nwe}, 72'd0);
        chk("rst_b_data", {b_hdin, b_ndin[7:0]}, 72'd0);
        chk("rst_b_cnt", {b_last, b_iss}, 72'd0);
        rst = 1'b0;
        tick();

        // Basic single lane: nonces 0x10..0x12
        hdr[0] = 32'h0000_0010;
        nonce_size = 32'd3;
        for (int i = 0; i < 3; i++) push_frame(1'b0, 4'd0, 32'h10 + 32'(i));
        h0 = a_hw_n; d0 = a_done_n;
        start_job(1'b0);
        send_hdr(1'b0, 20, 1'b1);
        chk("a_arm_no_write", a_hwe, 72'd0);
        tick();
        chk("a_first_write_latency", a_hwe, 72'd1);
        chk("a_first_is_pad", a_hdin, c_PAD);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (9) tick();
        chk("a_beat10_first_frame", a_hdin, {8'd0, 32'hC0DE_0001, 32'h1000_0000});
        wait_idle(1'b0, 200);
        chk("a_hashin_writes", a_hw_n - h0, 72'd33);
        chk("a_done_after_last_beat", a_done_cyc, 72'(a_last_hw + 1));
        chk("a_done_pulses", a_done_n - d0, 72'd1);
        chk("a_issued_cnt", a_iss, 72'd3);
        chk("a_nonce_last", a_last, 72'h12);
        chk("a_queues_drained", qha.size() + qna.size(), 72'd0);

        // Round-robin with lane 1 blocked: s = 0x100 + 6 = 0x106
        hdr[0] = 32'h0000_0100;
        nonce_size = 32'd6;
        b_nfull = 4'b0010;
        push_frame(1'b1, 4'd0, 32'h106); push_frame(1'b1, 4'd2, 32'h107);
        push_frame(1'b1, 4'd3, 32'h108); push_frame(1'b1, 4'd0, 32'h109);
        push_frame(1'b1, 4'd2, 32'h10A); push_frame(1'b1, 4'd3, 32'h10B);
        d0 = b_done_n;
        start_job(1'b1);
        send_hdr(1'b1, 20, 1'b0);
        wait_idle(1'b1, 300);
        b_nfull = 4'b0000;
        chk("rr_issued_cnt", b_iss, 72'd6);
        chk("rr_nonce_last", b_last, 72'h10B);
        chk("rr_done_pulses", b_done_n - d0, 72'd1);
        chk("rr_queues_drained", qhb.size() + qnb.size(), 72'd0);

        // Saturation at 2^32: s = 0xFFFFFFF8
        hdr[0] = 32'hFFFF_FFF0;
        nonce_size = 32'd8;
        for (int i = 0; i < 8; i++) push_frame(1'b1, 4'(i % 4), 32'hFFFF_FFF8 + 32'(i));
        d0 = b_done_n;
        start_job(1'b1);
        send_hdr(1'b1, 20, 1'b0);
        wait_idle(1'b1, 300);
        chk("sat_nonce_last", b_last, 72'hFFFF_FFFF);
        chk("sat_issued_cnt", b_iss, 72'd8);
        chk("sat_done_after_last_beat", b_done_cyc, 72'(b_last_hw + 1));
        chk("sat_done_pulses", b_done_n - d0, 72'd1);
        chk("sat_queues_drained", qhb.size() + qnb.size(), 72'd0);

        // Empty range: size 0, then a start beyond 2^32
        hdr[0] = 32'h0000_0400;
        nonce_size = 32'd0;
        h0 = b_hw_n;
        start_job(1'b1);
        send_hdr(1'b1, 20, 1'b0);
        chk("empty_done_in_arm", {b_done, b_hwe}, 72'h10);
        tick();
        chk("empty_idle_after", {b_busy, b_done}, 72'd0);
        chk("empty_issued_cnt", b_iss, 72'd0);
        hdr[0] = 32'hFFFF_FFF0;
        nonce_size = 32'h20;
        start_job(1'b1);
        send_hdr(1'b1, 20, 1'b0);
        chk("empty_sat_done_in_arm", b_done, 72'd1);
        tick();
        chk("empty_no_writes", b_hw_n - h0, 72'd0);

        // Stop at beat 4, stall beat 7 for 5 cycles: s = 0x200 + 4 = 0x204
        hdr[0] = 32'h0000_0200;
        nonce_size = 32'd4;
        push_frame(1'b1, 4'd0, 32'h204);
        n0 = b_nw_n; d0 = b_done_n;
        start_job(1'b1);
        send_hdr(1'b1, 20, 1'b0);
        k = 0; g = 0;
        while (k < 7 && g < 100) begin
            tick(); g++;
            if (|b_hwe) begin
                k++;
                if (k == 5) stop = 1'b1;
            end
        end
        chk("stop_beats_seen", k, 72'd7);
        tick();
        b_hfull = 4'b0001;
        repeat (5) tick();
        b_hfull = 4'b0000;
        wait_idle(1'b1, 100);
        stop = 1'b0;
        chk("stall_frame_span", b_last_hw - b_last_nw, 72'd15);
        chk("stop_done_in_sel", b_done_cyc, 72'(b_last_hw + 1));
        chk("stop_no_new_nonce", b_nw_n - n0, 72'd1);
        chk("stop_done_pulses", b_done_n - d0, 72'd1);
        chk("stop_issued_cnt", b_iss, 72'd1);
        chk("stop_queues_drained", qhb.size() + qnb.size(), 72'd0);

        // Reset mid-LOAD, then a fresh job from lane 0: s = 0x300 + 1
        hdr[0] = 32'h0000_0300;
        nonce_size = 32'd1;
        start_job(1'b1);
        send_hdr(1'b1, 7, 1'b0);
        chk("midload_ready", b_rdy, 72'd1);
        rst = 1'b1;
        tick();
        chk("rst_mid_ctrl", {b_rdy, b_busy, b_done, b_hwe, b_nwe}, 72'd0);
        chk("rst_mid_cnt", {b_last, b_iss}, 72'd0);
        chk("rst_a_nonce_last", a_last, 72'd0);
        rst = 1'b0;
        tick();
        push_frame(1'b1, 4'd0, 32'h301);
        start_job(1'b1);
        send_hdr(1'b1, 20, 1'b0);
        wait_idle(1'b1, 100);
        chk("fresh_issued_cnt", b_iss, 72'd1);
        chk("fresh_nonce_last", b_last, 72'h301);
        chk("fresh_queues_drained", qhb.size() + qnb.size(), 72'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nonce_gen_mc.md
# nonce_gen_mc

Multi-lane successor to the single-lane nonce generator in the oBTC miner datapath. Accepts an 80-byte block header as 20 handshaked 32-bit words. Enumerates this instance's nonce slice and distributes one 11-beat hash-input frame per nonce across `NUM_LANES` hash cores. Per frame, lane choice is round-robin with full-lane skipping. Adds a 33-bit saturating range, frame-boundary stop, and completion reporting.

## Interface
- `NUM_LANES`, 4: number of hash lanes (1-16).
- `NONCE_COEF`, 1: instance index (≥1); the slice starts at `w0 + nonce_size*(NONCE_COEF-1)`.
- `PAD_WORD`, 64'h8000000000000280: frame beat 0.
- `clk` in 1: clock.
- `rst` in 1: reset rst, synchronous, active-high; clock clk.
- `start` in 1: begin a job; sampled only in IDLE.
- `stop` in 1: level; abort the job at the next frame boundary.
- `hdr_valid` in 1, `hdr_data` in 32, `hdr_ready` out 1: header word stream; a word transfers when valid&ready.
- `nonce_size` in 32: slice length; sampled in ARM.
- `hashin_we` out NUM_LANES, `hashin_din` out 64, `hashin_full` in NUM_LANES: per-lane hash-input FIFO write port; data bus is shared.
- `nonce_we` out NUM_LANES, `nonce_din` out 32, `nonce_full` in NUM_LANES: per-lane nonce FIFO write port.
- `busy` out 1: high outside IDLE.
- `done` out 1: one-cycle pulse when a job ends (range exhausted or stopped).
- `nonce_last` out 32: last nonce to be issued, inclusive.
- `issued_cnt` out 32: frames issued in the current or last job.

## Operation
- States are IDLE, LOAD, ARM, SEL, FRAME.
- **IDLE**
  - `hdr_ready`=0.
  - On `start`: clear the word counter and `issued_cnt`, then go to LOAD.
- **LOAD**
  - `hdr_ready`=1.
  - Each transfer stores word wk, k=0..19.
  - After w19 transfers, go to ARM.
- **ARM** (one cycle)
  - Compute in 64-bit: s = w0 + nonce_size*(NONCE_COEF-1) and e = w0 + nonce_size*NONCE_COEF.
  - Exclusive end E = min(e, 2^32). If s ≥ E: pulse `done` and go to IDLE.
  - Otherwise load the 33-bit counter n=s, set `nonce_last`=E-1, and go to SEL.
- **SEL**
  - If `stop`: pulse `done` and go to IDLE.
  - Otherwise, starting at pointer p, pick the first lane L (cyclic) with `hashin_full[L]`=0 and `nonce_full[L]`=0. If no lane qualifies, hold in SEL.
  - On selection, in the same cycle:
    - `hashin_we[L]`=1 with `hashin_din`=PAD_WORD.
    - `nonce_we[L]`=1 with `nonce_din`=n[31:0].
    - Latch L and set p=(L+1) mod NUM_LANES.
    - Clear the beat counter b and go to FRAME.
- **FRAME**
  - Beats b=1..10 go to lane L only.
  - The frame image is the 640-bit value {w19,…,w1,bswap(n[31:0])}, sent MSB-first: beat 1={w19,w18}, …, beat 10={w1,bswap(n)}.
  - A beat is written when `hashin_full[L]`=0; otherwise that beat stalls. `stop` is ignored inside a frame.
  - After beat 10: n=n+1, `issued_cnt`+1.
  - If n=E: pulse `done` and go to IDLE. Else go to SEL.
- `bswap` reverses the byte order of a 32-bit word.
- Outputs not named as asserted in a state are 0. `hashin_din`/`nonce_din` are 0 when no write enable is asserted.
- At most one bit of `hashin_we` is set per cycle. `nonce_we` is set only in SEL.
- The pointer p persists across jobs and is cleared only by `rst`.

## Timing
- Reset values:
  - state IDLE, p=0.
  - All outputs 0, including `nonce_last` and `issued_cnt`.
  - Header registers and n are cleared.
- `start`→`hdr_ready` high: 1 cycle.
- Last header word → first frame write: 2 cycles (ARM, then SEL writes), when no FIFO is full.
- Unstalled frame: 11 cycles (SEL + 10 FRAME). Steady throughput is 1 nonce per 11 cycles.
- `done` asserts the cycle after the final beat, or in ARM/SEL for empty-range and stop.
- `rst` mid-frame: immediate return to reset state. A partial frame may remain in the FIFO; the system flushes the FIFOs.
- `start` while `busy` is ignored.
- `nonce_size`/`hdr_*` changes outside LOAD/ARM have no effect.

## Test plan
- **Basic, 1 lane:** NUM_LANES=1, w0=0x00000010, nonce_size=3, no full.
  - Nonces 0x10, 0x11, 0x12; 33 hashin writes, first = PAD_WORD.
  - Beat 10 of the first frame = {w1, 32'h10000000}.
  - `done` one cycle after the last beat; `issued_cnt`=3.
- **Round-robin skip:** NUM_LANES=4, nonce_size=6, `nonce_full[1]` held high.
  - Frame lanes in order 0, 2, 3, 0, 2, 3.
- **Saturation:** NONCE_COEF=2, w0=0xFFFFFFF0, nonce_size=8.
  - s = 0xFFFFFFF8, `nonce_last` = 0xFFFFFFFF.
  - 8 frames, the last with nonce 0xFFFFFFFF; no wrap to 0.
- **Empty range:** nonce_size=0.
  - `done` in ARM; zero writes.
- **Stop and stall:** assert `stop` at FRAME beat 4; assert `hashin_full[L]` for 5 cycles at beat 7.
  - The frame completes with beats in order and exactly 5 stall cycles.
  - `done` pulses in the next SEL; no new `nonce_we`.
- **Reset:** `rst` mid-LOAD after 7 words.
  - All outputs 0; state IDLE.
  - A fresh `start` plus 20 words completes normally.
